// File: rtl/periph_ctrl_multi_timer.sv
// Memory-mapped peripheral block: LED/digital output registers, free-running
// SYSTICK, NUM_TIMERS reload timers with one-shot mode and W1C interrupt flags.
module periph_ctrl_multi_timer #(
  parameter int          NUM_TIMERS  = 2,
  parameter int          TIMER_WIDTH = 32,
  parameter int          LED_WIDTH   = 8,
  parameter int          DIGI_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [31:0]           Write_Data,
  input  logic                  PeripheralControl_Read,
  input  logic                  PeripheralControl_Write,
  output logic [31:0]           Read_Data,
  output logic [LED_WIDTH-1:0]  led,
  output logic [DIGI_WIDTH-1:0] digital,
  output logic                  irq,
  output logic [NUM_TIMERS-1:0] irq_vec
);

  // Window size in 32-bit words: four global registers, four reserved words,
  // then four words per timer channel.
  localparam int WIN_WORDS = 8 + 4 * NUM_TIMERS;

  localparam logic [29:0] W_LED     = 30'd0;
  localparam logic [29:0] W_DIGI    = 30'd1;
  localparam logic [29:0] W_SYSTICK = 30'd2;
  localparam logic [29:0] W_IRQST   = 30'd3;

  localparam logic [1:0] F_TH   = 2'd0;
  localparam logic [1:0] F_TL   = 2'd1;
  localparam logic [1:0] F_TCON = 2'd2;

  logic [29:0]           woff;
  logic                  hit;
  logic                  wr_en;
  logic [NUM_TIMERS-1:0] tsel;
  logic [NUM_TIMERS-1:0] ovf;

  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic [DIGI_WIDTH-1:0]  digi_q, digi_d;
  logic [31:0]            systick_q, systick_d;
  logic [TIMER_WIDTH-1:0] th_q [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] th_d [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] tl_q [NUM_TIMERS];
  logic [TIMER_WIDTH-1:0] tl_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0]  en_q, en_d;
  logic [NUM_TIMERS-1:0]  ie_q, ie_d;
  logic [NUM_TIMERS-1:0]  flag_q, flag_d;
  logic [NUM_TIMERS-1:0]  os_q, os_d;

  // Addresses below BASE_ADDR wrap to huge word offsets and fall out of range.
  assign woff  = Address[31:2] - BASE_ADDR[31:2];
  assign hit   = (Address[1:0] == 2'b00) && (woff < 30'(WIN_WORDS));
  assign wr_en = PeripheralControl_Write && hit;

  always_comb begin
    for (int k = 0; k < NUM_TIMERS; k++) begin
      tsel[k] = (woff[29:2] == 28'(2 + k));
      ovf[k]  = en_q[k] && (tl_q[k] == '1);
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;
    en_d      = en_q;
    ie_d      = ie_q;
    flag_d    = flag_q;
    os_d      = os_q;

    if (wr_en && woff == W_LED)  led_d  = Write_Data[LED_WIDTH-1:0];
    if (wr_en && woff == W_DIGI) digi_d = Write_Data[DIGI_WIDTH-1:0];

    for (int k = 0; k < NUM_TIMERS; k++) begin
      th_d[k] = th_q[k];
      tl_d[k] = tl_q[k];

      // Counting first; a bus write below overrides it in the same cycle.
      if (en_q[k]) tl_d[k] = ovf[k] ? th_q[k] : tl_q[k] + TIMER_WIDTH'(1);
      if (ovf[k] && os_q[k]) en_d[k] = 1'b0;

      if (wr_en && tsel[k]) begin
        case (woff[1:0])
          F_TH: th_d[k] = Write_Data[TIMER_WIDTH-1:0];
          F_TL: tl_d[k] = Write_Data[TIMER_WIDTH-1:0];
          F_TCON: begin
            en_d[k] = Write_Data[0];
            ie_d[k] = Write_Data[1];
            os_d[k] = Write_Data[3];
            if (Write_Data[2]) flag_d[k] = 1'b0;
          end
          default: ;
        endcase
      end

      if (wr_en && woff == W_IRQST && Write_Data[k]) flag_d[k] = 1'b0;
      // An overflow in the same cycle as a clear must not be lost.
      if (ovf[k] && ie_q[k]) flag_d[k] = 1'b1;
    end
  end

  // NOTE: the timer register arrays are ordinary flops and are cleared on reset
  // like any other state; a running timer must not survive a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      en_q      <= '0;
      ie_q      <= '0;
      flag_q    <= '0;
      os_q      <= '0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
        th_q[k] <= '0;
        tl_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      flag_q    <= flag_d;
      os_q      <= os_d;
      th_q      <= th_d;
      tl_q      <= tl_d;
    end
  end

  always_comb begin
    Read_Data = '0;
    if (PeripheralControl_Read && hit) begin
      case (woff)
        W_LED:     Read_Data = 32'(led_q);
        W_DIGI:    Read_Data = 32'(digi_q);
        W_SYSTICK: Read_Data = systick_q;
        W_IRQST:   Read_Data = 32'(flag_q);
        default: begin
          for (int k = 0; k < NUM_TIMERS; k++) begin
            if (tsel[k]) begin
              case (woff[1:0])
                F_TH:    Read_Data = 32'(th_q[k]);
                F_TL:    Read_Data = 32'(tl_q[k]);
                F_TCON:  Read_Data = {28'd0, os_q[k], flag_q[k], ie_q[k], en_q[k]};
                default: Read_Data = '0;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign led     = led_q;
  assign digital = digi_q;
  assign irq_vec = flag_q;
  assign irq     = |flag_q;

endmodule
